// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder4.sv
// Combinational 4-bit adder slice with carry-in and carry-out.
module adder4
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               C0,
    output logic [SLICE_W-1:0] F,
    output logic               C4
);

    logic [SLICE_W:0] sum;

    assign sum = {1'b0, A} + {1'b0, B} + (SLICE_W+1)'(C0);
    assign F   = sum[SLICE_W-1:0];
    assign C4  = sum[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle adder: one 4-bit slice reused per nibble, LSB nibble first.
module nibble_serial_adder16
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             C16,
    output logic             OF,
    output logic             ZF
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_f;
    logic               slice_c;
    logic               msb_cin;
    logic               last_nibble;

    // Select the operand nibble addressed by the running index.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx == IDX_W'(k)) begin
                slice_a = a_q[k*SLICE_W +: SLICE_W];
                slice_b = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    adder4 u_slice (
        .A  (slice_a),
        .B  (slice_b),
        .C0 (carry_q),
        .F  (slice_f),
        .C4 (slice_c)
    );

    // Carry into the slice MSB recovered from its sum bit, for overflow.
    assign msb_cin     = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_f[SLICE_W-1];
    assign last_nibble = (idx == IDX_W'(N - 1));
    assign ZF          = (F == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            F       <= '0;
            C16     <= 1'b0;
            OF      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        idx     <= '0;
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C0;
                        F       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int k = 0; k < int'(N); k++) begin
                        if (idx == IDX_W'(k)) begin
                            F[k*SLICE_W +: SLICE_W] <= slice_f;
                        end
                    end
                    carry_q <= slice_c;
                    if (last_nibble) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        C16   <= slice_c;
                        OF    <= msb_cin ^ slice_c;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Directed-vector bench for the nibble-serial adder, WIDTH=16.
module tb_nibble_serial_adder16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        C0;
    logic        busy;
    logic        done;
    logic [15:0] F;
    logic        C16;
    logic        OF;
    logic        ZF;

    int n_checks;
    int n_pass;

    nibble_serial_adder16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C0    (C0),
        .busy  (busy),
        .done  (done),
        .F     (F),
        .C16   (C16),
        .OF    (OF),
        .ZF    (ZF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present operands with start high across one edge, then drop start.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c0);
        start = 1'b1;
        A     = a;
        B     = b;
        C0    = c0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted from the edge that accepted start; 1 already elapsed.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c0, input logic [15:0] ef, input logic ec,
                           input logic eof, input logic ezf);
        int edges;
        launch(a, b, c0);
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        wait_done(edges);
        chk({tag, "_latency"}, 32'(edges), 32'd5);
        chk({tag, "_F"},   32'(F),   32'(ef));
        chk({tag, "_C16"}, 32'(C16), 32'(ec));
        chk({tag, "_OF"},  32'(OF),  32'(eof));
        chk({tag, "_ZF"},  32'(ZF),  32'(ezf));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_F_hold"}, 32'(F), 32'(ef));
    endtask

    initial begin
        int edges;
        int pulses;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        C0    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_F",    32'(F),    32'd0);
        chk("rst_ZF",   32'(ZF),   32'd1);
        chk("rst_C16",  32'(C16),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_add("a8888", 16'h8888, 16'h8888, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0);
        run_add("a9999", 16'h9999, 16'h9999, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b0);
        run_add("abbbb", 16'hBBBB, 16'hBBBB, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b0);
        run_add("affff", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_add("a7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Start re-pulsed mid-run with different operands must be ignored.
        launch(16'h0001, 16'h0001, 1'b0);
        start = 1'b1;
        A     = 16'h1234;
        B     = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_F", 32'(F), 32'h0002);

        // Back-to-back: start held in the done cycle goes straight to RUN.
        launch(16'h0010, 16'h0020, 1'b0);
        wait_done(edges);
        chk("b2b_first_F", 32'(F), 32'h0030);
        launch(16'h0003, 16'h0004, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(edges);
        chk("b2b_latency", 32'(edges), 32'd5);
        chk("b2b_F", 32'(F), 32'h0007);
        @(posedge clk);
        #1;

        // Reset in the middle of a run discards it.
        launch(16'h1111, 16'h1111, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_F",    32'(F),    32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_OF",   32'(OF),   32'd0);
        run_add("a00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
